// File: rtl/sum_block_accumulator.sv
// Accumulates BLK_LEN unsigned adder sums into an ACC_W-bit block total with overflow flag.
// Define SUM_ACC_SAT_EN to clamp the total to all-ones on overflow instead of wrapping.
module sum_block_accumulator #(
    parameter  int NUM     = 8,
    parameter  int ACC_W   = 16,
    parameter  int BLK_LEN = 4,
    localparam int CNT_W   = $clog2(BLK_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [NUM:0]     sum_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] cnt_o
);

    typedef enum logic {ACCUM, HOLD} state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]   add_full;
    logic             carry;

    always_comb begin
        add_full = {1'b0, acc_q} + {{(ACC_W - NUM){1'b0}}, sum_i};
        carry    = add_full[ACC_W];
`ifdef SUM_ACC_SAT_EN
        // Once clamped, any further non-zero add carries again, so the total stays pinned.
        acc_d    = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        acc_d    = add_full[ACC_W-1:0];
`endif
        ovf_d    = ovf_q | carry;
        cnt_d    = cnt_q + CNT_W'(1);
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(BLK_LEN - 1)) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == HOLD);
    assign acc_o       = acc_q;
    assign ovf_o       = ovf_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Scoreboard bench for sum_block_accumulator: default build, a narrow overflow build, and BLK_LEN=1.
module tb_sum_block_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // DUT A: NUM=8, ACC_W=16, BLK_LEN=4
    logic        clear_a = 0, in_valid_a = 0, out_ready_a = 0;
    logic [8:0]  sum_a = '0;
    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] acc_a;
    logic [2:0]  cnt_a;
    // DUT B: NUM=8, ACC_W=10, BLK_LEN=3
    logic        clear_b = 0, in_valid_b = 0, out_ready_b = 0;
    logic [8:0]  sum_b = '0;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [9:0]  acc_b;
    logic [1:0]  cnt_b;
    // DUT C: NUM=8, ACC_W=16, BLK_LEN=1
    logic        clear_c = 0, in_valid_c = 0, out_ready_c = 0;
    logic [8:0]  sum_c = '0;
    logic        in_ready_c, out_valid_c, ovf_c;
    logic [15:0] acc_c;
    logic [0:0]  cnt_c;

    sum_block_accumulator #(.NUM(8), .ACC_W(16), .BLK_LEN(4)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear_a), .in_valid_i(in_valid_a),
        .in_ready_o(in_ready_a), .sum_i(sum_a), .out_valid_o(out_valid_a),
        .out_ready_i(out_ready_a), .acc_o(acc_a), .ovf_o(ovf_a), .cnt_o(cnt_a));
    sum_block_accumulator #(.NUM(8), .ACC_W(10), .BLK_LEN(3)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear_b), .in_valid_i(in_valid_b),
        .in_ready_o(in_ready_b), .sum_i(sum_b), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready_b), .acc_o(acc_b), .ovf_o(ovf_b), .cnt_o(cnt_b));
    sum_block_accumulator #(.NUM(8), .ACC_W(16), .BLK_LEN(1)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear_c), .in_valid_i(in_valid_c),
        .in_ready_o(in_ready_c), .sum_i(sum_c), .out_valid_o(out_valid_c),
        .out_ready_i(out_ready_c), .acc_o(acc_c), .ovf_o(ovf_c), .cnt_o(cnt_c));

    // Expected entries: {ovf, acc[15:0]}
    logic [16:0] q_a[$], q_b[$], q_c[$];
    int hs_a = 0, hs_b = 0, hs_c = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] blk_exp(input int unsigned total, input int w);
        int unsigned lim;
        lim = 32'd1 << w;
        if (total >= lim) blk_exp = {1'b1, SAT ? 16'(lim - 1) : 16'(total % lim)};
        else              blk_exp = {1'b0, 16'(total)};
    endfunction

    // Output monitors: a handshake completes on the next rising edge unless reset/clear wins.
    always @(negedge clk) begin
        if (rst_n && !clear_a && out_valid_a && out_ready_a) begin
            logic [16:0] e;
            hs_a++;
            if (q_a.size() == 0) check("a_sb_unexpected", 1, 0);
            else begin
                e = q_a.pop_front();
                check("a_acc", 32'(acc_a), 32'(e[15:0]));
                check("a_ovf", 32'(ovf_a), 32'(e[16]));
            end
        end
        if (rst_n && !clear_b && out_valid_b && out_ready_b) begin
            logic [16:0] e;
            hs_b++;
            if (q_b.size() == 0) check("b_sb_unexpected", 1, 0);
            else begin
                e = q_b.pop_front();
                check("b_acc", 32'(acc_b), 32'(e[15:0]));
                check("b_ovf", 32'(ovf_b), 32'(e[16]));
            end
        end
        if (rst_n && !clear_c && out_valid_c && out_ready_c) begin
            logic [16:0] e;
            hs_c++;
            if (q_c.size() == 0) check("c_sb_unexpected", 1, 0);
            else begin
                e = q_c.pop_front();
                check("c_acc", 32'(acc_c), 32'(e[15:0]));
                check("c_ovf", 32'(ovf_c), 32'(e[16]));
            end
        end
    end

    task automatic send_a(input int unsigned s);
        in_valid_a = 1'b1;
        sum_a = 9'(s);
        tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        // Reset held two edges with a valid sample presented
        in_valid_a = 1'b1; sum_a = 9'd5; out_ready_a = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_acc", 32'(acc_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        rst_n = 1'b1; in_valid_a = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready_a), 1);
        check("rst_cnt_after", 32'(cnt_a), 0);

        // Full block of 9'h1FF back-to-back
        h0 = hs_a;
        q_a.push_back(blk_exp(4 * 511, 16));
        for (int i = 0; i < 4; i++) send_a(511);
        in_valid_a = 1'b0;
        check("full_out_valid", 32'(out_valid_a), 1);
        check("full_acc", 32'(acc_a), 32'h07FC);
        check("full_cnt", 32'(cnt_a), 4);
        tick();
        check("full_out_valid_drop", 32'(out_valid_a), 0);
        check("full_next_acc", 32'(acc_a), 0);
        check("full_next_cnt", 32'(cnt_a), 0);
        check("full_hs_once", 32'(hs_a - h0), 1);

        // Backpressure with a pending input sample
        out_ready_a = 1'b0;
        q_a.push_back(blk_exp(10, 16));
        for (int i = 1; i <= 4; i++) send_a(i);
        sum_a = 9'd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_acc", 32'(acc_a), 10);
            check("bp_in_ready", 32'(in_ready_a), 0);
            check("bp_out_valid", 32'(out_valid_a), 1);
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready_a), 1);
        check("bp_release_cnt", 32'(cnt_a), 0);
        tick();
        check("bp_pending_cnt", 32'(cnt_a), 1);
        check("bp_pending_acc", 32'(acc_a), 9);
        // Clear together with an input handshake: clear wins
        sum_a = 9'd50; clear_a = 1'b1;
        tick();
        clear_a = 1'b0; in_valid_a = 1'b0;
        check("clr_hs_cnt", 32'(cnt_a), 0);
        check("clr_hs_acc", 32'(acc_a), 0);

        // Clear mid-block, then a clean block of 5s
        send_a(100); send_a(200);
        in_valid_a = 1'b0;
        check("mid_cnt", 32'(cnt_a), 2);
        check("mid_acc", 32'(acc_a), 300);
        clear_a = 1'b1; tick(); clear_a = 1'b0;
        check("clr_cnt", 32'(cnt_a), 0);
        check("clr_acc", 32'(acc_a), 0);
        q_a.push_back(blk_exp(20, 16));
        for (int i = 0; i < 4; i++) send_a(5);
        in_valid_a = 1'b0;
        check("after_clr_acc", 32'(acc_a), 20);
        tick();

        // Reset asserted while holding a result
        out_ready_a = 1'b0;
        q_a.push_back(blk_exp(20, 16));
        for (int i = 0; i < 4; i++) send_a(5);
        in_valid_a = 1'b0;
        check("hold_out_valid", 32'(out_valid_a), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("hold_rst_out_valid", 32'(out_valid_a), 0);
        check("hold_rst_acc", 32'(acc_a), 0);
        check("hold_rst_q", 32'(q_a.size()), 1);
        q_a.delete();

        // Input gaps: valid every other cycle
        h0 = hs_a;
        q_a.push_back(blk_exp(28, 16));
        sum_a = 9'd7;
        for (int i = 0; i < 7; i++) begin
            in_valid_a = (i % 2 == 0);
            tick();
        end
        in_valid_a = 1'b0;
        check("gap_out_valid", 32'(out_valid_a), 1);
        check("gap_cnt", 32'(cnt_a), 4);
        check("gap_acc", 32'(acc_a), 28);
        out_ready_a = 1'b1;
        tick();
        check("gap_out_valid_drop", 32'(out_valid_a), 0);
        check("gap_hs_once", 32'(hs_a - h0), 1);

        // Overflow on the narrow build
        out_ready_b = 1'b1;
        q_b.push_back(blk_exp(3 * 511, 10));
        for (int i = 0; i < 3; i++) begin
            in_valid_b = 1'b1; sum_b = 9'd511; tick();
        end
        in_valid_b = 1'b0;
        check("ovf_out_valid", 32'(out_valid_b), 1);
        check("ovf_acc", 32'(acc_b), SAT ? 32'h3FF : 32'd509);
        check("ovf_flag", 32'(ovf_b), 1);
        tick();
        check("ovf_next_acc", 32'(acc_b), 0);
        check("ovf_next_flag", 32'(ovf_b), 0);

        // Single-sample blocks
        q_c.push_back(blk_exp(300, 16));
        in_valid_c = 1'b1; sum_c = 9'd300; tick();
        in_valid_c = 1'b0;
        check("one_out_valid", 32'(out_valid_c), 1);
        check("one_cnt", 32'(cnt_c), 1);
        check("one_acc", 32'(acc_c), 300);
        out_ready_c = 1'b1; tick();
        check("one_out_valid_drop", 32'(out_valid_c), 0);

        tick();
        check("a_sb_drained", 32'(q_a.size()), 0);
        check("b_sb_drained", 32'(q_b.size()), 0);
        check("c_sb_drained", 32'(q_c.size()), 0);
        check("b_hs", 32'(hs_b), 1);
        check("c_hs", 32'(hs_c), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the adder's (NUM+1)-bit sum output.
- Accepts a stream of sums over a valid/ready handshake and accumulates exactly BLK_LEN samples into an ACC_W-bit total.
- Presents each block total, with an overflow flag, on a valid/ready output port.
- Sits between the adder datapath and the result checker/logging stage.

Parameters:
- NUM, 8, adder operand width; input sum width is NUM+1.
- ACC_W, 16, accumulator/output width; must be >= NUM+1.
- BLK_LEN, 4, number of samples per block; must be >= 1.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-low (0 = reset).
- clear_i  input  1  synchronous block abort/clear, active-high.
- in_valid_i  input  1  sum_i is valid this cycle.
- in_ready_o  output  1  block can accept a sample this cycle.
- sum_i  input  NUM+1  unsigned sum from the adder.
- out_valid_o  output  1  acc_o/ovf_o hold a completed block result.
- out_ready_i  input  1  downstream accepts the result.
- acc_o  output  ACC_W  block total.
- ovf_o  output  1  total exceeded 2^ACC_W-1 during this block.
- cnt_o  output  $clog2(BLK_LEN+1)  samples accepted in current block.

Behaviour:
- Reset (rst_i==0 at a clk_i edge):
  - state=ACCUM; acc_o=0, ovf_o=0, cnt_o=0, out_valid_o=0.
  - in_ready_o=1 from the first cycle after reset deasserts.
  - Reset has priority over everything, including mid-block and HOLD.
- clear_i: priority below reset, above all else. Same effect as reset on the next edge; any in-flight sample or result is discarded.
- FSM has two states:
  - ACCUM: in_ready_o=1, out_valid_o=0. On in_valid_i & in_ready_o:
    - acc <= acc + zero-extended sum_i;
    - cnt <= cnt+1;
    - ovf <= ovf | carry-out of the ACC_W-bit add.
    - If this is sample BLK_LEN (cnt==BLK_LEN-1 before the edge), go to HOLD.
  - HOLD: in_ready_o=0, out_valid_o=1. acc_o, ovf_o and cnt_o (==BLK_LEN) are stable. On out_valid_o & out_ready_i, go to ACCUM and clear acc, ovf and cnt to 0 on the same edge.
- Output timing:
  - out_valid_o rises on the edge that accepts the last sample (registered; visible 1 cycle after that sample is presented).
  - Throughput is one block per BLK_LEN+1 cycles minimum (one HOLD cycle per block).
- Handshake rules:
  - out_valid_o and acc_o never change while out_valid_o=1 and out_ready_i=0.
  - in_ready_o does not depend combinationally on in_valid_i.
  - in_ready_o depends only on state.
- Simultaneous events:
  - In HOLD, in_valid_i=1 together with the output handshake: the sample is NOT accepted that cycle (in_ready_o=0). It is accepted the next cycle at the earliest.
  - clear_i together with an input or output handshake: clear wins; the transfer is dropped.
- Idle input: in_valid_i gaps are allowed; acc and cnt hold.
- BLK_LEN=1: every accepted sample goes directly to HOLD with acc_o=sum_i.
- Arithmetic: unsigned only. The internal add is ACC_W+1 bits wide; bit ACC_W is the carry.
- Overflow without the optional feature: the total wraps modulo 2^ACC_W and ovf_o is sticky for the rest of the block.

Optional Feature:
- Macro: SUM_ACC_SAT_EN.
- Defined: on carry-out, acc clamps to all-ones (2^ACC_W-1) and stays there for the rest of the block (later adds keep it clamped); ovf_o=1.
- Undefined: modulo wrap as described above; ovf_o is still set.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset: hold rst_i=0 for 2 edges with in_valid_i=1 -> out_valid_o=0, acc_o=0, ovf_o=0, cnt_o=0, no sample counted. After release, in_ready_o=1.
- Full block (NUM=8, ACC_W=16, BLK_LEN=4): four back-to-back sums of 9'h1FF with out_ready_i=1 -> out_valid_o for one cycle with acc_o=16'h07FC, ovf_o=0. The next block starts at 0.
- Backpressure: complete a block of 1,2,3,4, then hold out_ready_i=0 for 5 cycles with in_valid_i=1 -> acc_o=10 stable, in_ready_o=0 throughout, no sample lost. On out_ready_i=1, handshake happens and the pending sample is accepted the following cycle.
- Overflow (ACC_W=10, BLK_LEN=3): sums 511, 511, 511 -> without the macro acc_o=509 and ovf_o=1; with SUM_ACC_SAT_EN acc_o=10'h3FF and ovf_o=1.
- Clear/reset mid-block: accept 2 of 4 samples (sum 300), pulse clear_i for 1 cycle -> cnt_o=0, acc_o=0. Then 4 samples of 5 -> acc_o=20. Repeat with rst_i=0 asserted during HOLD -> out_valid_o=0 the next cycle.
- Input gaps: feed BLK_LEN=4 samples of 7 with in_valid_i toggling every other cycle -> acc_o=28, out_valid_o asserted exactly once, cnt_o=4 in HOLD.
